riscv_core_hazard_unit: RTL and testbench

Pipeline hazard controller for the five-stage RV64IMAC core (IF/ID/EX/MEM/WB). Generates the 2-bit select for the two EX-stage operand forwarding 3:1 muxes. Generates stall/flush controls for load-use hazards and taken branches/jumps. Sequences the multi-cycle M-extension unit (mul/div) with a start/done handshake and holds the pipeline while it runs.

---
 rtl/riscv_core_hazard_unit.sv | 149 ++++++++++++++
 tb/tb_riscv_core_hazard_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_hazard_unit.sv
// Hazard controller for the 5-stage core: EX operand forwarding, load-use/branch
// stall+flush, and mul/div sequencing. Define RISCV_CORE_HAZARD_PERF_EN for stall/flush counters.

// One forwarding select: MEM beats WB, x0 never forwarded.
module riscv_core_hazard_fwd #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              mem_regwrite,
  input  logic              wb_regwrite,
  output logic [1:0]        sel
);
  always_comb begin
    sel = 2'b00;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs))     sel = 2'b10;
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs))   sel = 2'b01;
  end
endmodule

module riscv_core_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic [REG_AW-1:0] i_ex_rs1,
  input  logic [REG_AW-1:0] i_ex_rs2,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_is_load,
  input  logic              i_ex_is_md,
  input  logic              i_ex_br_taken,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_mem_regwrite,
  input  logic              i_wb_regwrite,
  input  logic              i_md_done,
  output logic [1:0]        o_fwd_a_sel,
  output logic [1:0]        o_fwd_b_sel,
  output logic              o_md_start,
  output logic              o_stall_if,
  output logic              o_stall_id,
  output logic              o_stall_ex,
  output logic              o_flush_id,
  output logic              o_flush_ex,
  output logic              o_flush_mem,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);
  localparam int NUM_OPS = 2;

  typedef enum logic {IDLE, MD_BUSY} md_state_e;
  md_state_e state, state_nxt;

  logic [NUM_OPS-1:0][REG_AW-1:0] ex_rs;
  logic [NUM_OPS-1:0][1:0]        fwd_sel;
  logic                           load_use, br_flush;

  assign ex_rs = {i_ex_rs2, i_ex_rs1};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    riscv_core_hazard_fwd #(.REG_AW(REG_AW)) u_fwd (
      .ex_rs        (ex_rs[g]),
      .mem_rd       (i_mem_rd),
      .wb_rd        (i_wb_rd),
      .mem_regwrite (i_mem_regwrite),
      .wb_regwrite  (i_wb_regwrite),
      .sel          (fwd_sel[g])
    );
  end

  // Outputs are forced quiet while reset is held.
  assign o_fwd_a_sel = i_rst ? 2'b00 : fwd_sel[0];
  assign o_fwd_b_sel = i_rst ? 2'b00 : fwd_sel[1];

  assign load_use = i_ex_is_load && (i_ex_rd != '0) &&
                    ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));
  assign br_flush = !i_rst && (state == IDLE) && i_ex_br_taken;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_ex_is_md && !i_ex_br_taken) state_nxt = MD_BUSY;
      MD_BUSY: if (i_md_done)                    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // While busy, branch and load-use are masked; the done cycle releases the hold.
  always_comb begin
    o_md_start  = 1'b0;
    o_stall_if  = 1'b0;
    o_stall_id  = 1'b0;
    o_stall_ex  = 1'b0;
    o_flush_id  = 1'b0;
    o_flush_ex  = 1'b0;
    o_flush_mem = 1'b0;
    if (!i_rst) begin
      case (state)
        IDLE: begin
          o_md_start = i_ex_is_md && !i_ex_br_taken;
          if (br_flush) begin
            o_flush_id = 1'b1;
            o_flush_ex = 1'b1;
          end else if (load_use) begin
            o_stall_if = 1'b1;
            o_stall_id = 1'b1;
            o_flush_ex = 1'b1;
          end
        end
        MD_BUSY: begin
          o_stall_if  = !i_md_done;
          o_stall_id  = !i_md_done;
          o_stall_ex  = !i_md_done;
          o_flush_mem = !i_md_done;
        end
        default: ;
      endcase
    end
  end

`ifdef RISCV_CORE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (o_stall_if && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (br_flush   && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_riscv_core_hazard_unit.sv
// Randomized + directed check of riscv_core_hazard_unit against a rule-level model.
module tb_riscv_core_hazard_unit;
  localparam int AW = 5;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          ex_is_load, ex_is_md, ex_br, mem_we, wb_we, md_done;
  logic [1:0]    fa, fb;
  logic          md_start, s_if, s_id, s_ex, f_id, f_ex, f_mem;
  logic [CW-1:0] scnt, fcnt;

  always #5 clk = ~clk;

  riscv_core_hazard_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2), .i_ex_rd(ex_rd),
    .i_ex_is_load(ex_is_load), .i_ex_is_md(ex_is_md), .i_ex_br_taken(ex_br),
    .i_mem_rd(mem_rd), .i_wb_rd(wb_rd), .i_mem_regwrite(mem_we), .i_wb_regwrite(wb_we),
    .i_md_done(md_done), .o_fwd_a_sel(fa), .o_fwd_b_sel(fb), .o_md_start(md_start),
    .o_stall_if(s_if), .o_stall_id(s_id), .o_stall_ex(s_ex),
    .o_flush_id(f_id), .o_flush_ex(f_ex), .o_flush_mem(f_mem),
    .o_stall_cnt(scnt), .o_flush_cnt(fcnt)
  );

`ifdef RISCV_CORE_HAZARD_PERF_EN
  // Narrow counters to exercise saturation quickly.
  logic [1:0] d2_fa, d2_fb, d2_scnt, d2_fcnt;
  logic       d2_st, d2_sif, d2_sid, d2_sex, d2_fid, d2_fex, d2_fmem;
  riscv_core_hazard_unit #(.REG_AW(AW), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2), .i_ex_rd(ex_rd),
    .i_ex_is_load(ex_is_load), .i_ex_is_md(ex_is_md), .i_ex_br_taken(ex_br),
    .i_mem_rd(mem_rd), .i_wb_rd(wb_rd), .i_mem_regwrite(mem_we), .i_wb_regwrite(wb_we),
    .i_md_done(md_done), .o_fwd_a_sel(d2_fa), .o_fwd_b_sel(d2_fb), .o_md_start(d2_st),
    .o_stall_if(d2_sif), .o_stall_id(d2_sid), .o_stall_ex(d2_sex),
    .o_flush_id(d2_fid), .o_flush_ex(d2_fex), .o_flush_mem(d2_fmem),
    .o_stall_cnt(d2_scnt), .o_flush_cnt(d2_fcnt)
  );
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0] fa, fb;
    logic st, sif, sid, sex, fid, fex, fmem, brf;
  } exp_t;

  bit            busy_m = 1'b0;
  logic [CW-1:0] scnt_m = '0, fcnt_m = '0;
  bit            chk_en = 1'b0;

  function automatic logic [1:0] fwd_of(input logic [AW-1:0] rs);
    if (mem_we && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_we  && wb_rd  != 0 && wb_rd  == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t model();
    exp_t e = '0;
    bit lu;
    if (rst) return e;
    e.fa = fwd_of(ex_rs1);
    e.fb = fwd_of(ex_rs2);
    lu = ex_is_load && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    if (busy_m) begin
      {e.sif, e.sid, e.sex, e.fmem} = {4{!md_done}};
    end else begin
      e.st = ex_is_md && !ex_br;
      if (ex_br) begin
        e.fid = 1; e.fex = 1; e.brf = 1;
      end else if (lu) begin
        e.sif = 1; e.sid = 1; e.fex = 1;
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    e = model();
    if (rst) begin
      busy_m = 0; scnt_m = '0; fcnt_m = '0;
    end else begin
      if (e.sif && scnt_m != '1) scnt_m = scnt_m + 1;
      if (e.brf && fcnt_m != '1) fcnt_m = fcnt_m + 1;
      if (!busy_m && ex_is_md && !ex_br) busy_m = 1;
      else if (busy_m && md_done)        busy_m = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      e = model();
      chk("fwd_a", fa, e.fa);
      chk("fwd_b", fb, e.fb);
      chk("md_start", md_start, e.st);
      chk("stall_if", s_if, e.sif);
      chk("stall_id", s_id, e.sid);
      chk("stall_ex", s_ex, e.sex);
      chk("flush_id", f_id, e.fid);
      chk("flush_ex", f_ex, e.fex);
      chk("flush_mem", f_mem, e.fmem);
`ifdef RISCV_CORE_HAZARD_PERF_EN
      chk("stall_cnt", scnt, scnt_m);
      chk("flush_cnt", fcnt, fcnt_m);
`else
      chk("stall_cnt", scnt, 0);
      chk("flush_cnt", fcnt, 0);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {ex_is_load, ex_is_md, ex_br, mem_we, wb_we, md_done} = '0;
  endtask

  initial begin
    rst = 1'b1; clr();
    cyc(); chk_en = 1'b1;
    // hazards presented during reset must stay quiet
    mem_we = 1; mem_rd = 5; ex_rs1 = 5; ex_is_load = 1; ex_rd = 7; id_rs2 = 7; ex_is_md = 1;
    #2; chk("rst_fwd_a", fa, 2'b00); chk("rst_stall", s_if, 0); chk("rst_start", md_start, 0);
    cyc(); clr(); rst = 0;
    #2; chk("post_rst_all", {fa, fb, md_start, s_if, s_id, s_ex, f_id, f_ex, f_mem}, 0);

    cyc(); mem_we = 1; mem_rd = 5; wb_we = 1; wb_rd = 5; ex_rs1 = 5;
    #2; chk("fwd_mem_prio", fa, 2'b10);
    cyc(); mem_we = 0;
    #2; chk("fwd_wb", fa, 2'b01);
    cyc(); mem_we = 1; mem_rd = 0; wb_rd = 0; ex_rs1 = 0;
    #2; chk("fwd_x0", fa, 2'b00);
    cyc(); clr(); wb_we = 1; wb_rd = 9; ex_rs2 = 9;
    #2; chk("fwd_b_wb", fb, 2'b01); chk("fwd_a_none", fa, 2'b00);

    cyc(); clr(); ex_is_load = 1; ex_rd = 7; id_rs2 = 7;
    #2; chk("lu_stall", {s_if, s_id, f_ex, s_ex, f_id}, 5'b11100);
    cyc(); clr();
    #2; chk("lu_release", {s_if, s_id, f_ex}, 0);
    cyc(); ex_is_load = 1; ex_rd = 0; id_rs2 = 0;
    #2; chk("lu_x0", s_if, 0);
    cyc(); clr(); ex_is_load = 1; ex_rd = 7; id_rs1 = 7; ex_br = 1;
    #2; chk("br_over_lu", {f_id, f_ex, s_if, s_id}, 4'b1100);

    cyc(); clr(); ex_is_md = 1;
    #2; chk("md_c0_start", md_start, 1); chk("md_c0_stall", s_if, 0);
    for (int c = 1; c <= 3; c++) begin
      cyc(); ex_br = (c == 2);
      #2; chk("md_busy_hold", {s_if, s_id, s_ex, f_mem}, 4'b1111);
      chk("md_busy_nostart", md_start, 0); chk("md_busy_brmask", f_id, 0);
    end
    cyc(); ex_br = 0; md_done = 1;
    #2; chk("md_done_rel", {s_if, s_id, s_ex, f_mem, md_start}, 0);
    cyc(); clr();
    #2; chk("md_idle", {md_start, s_if}, 0);
`ifdef RISCV_CORE_HAZARD_PERF_EN
    chk("perf_stall4", scnt, 4);
    chk("perf_flush1", fcnt, 1);
    chk("perf_sat", d2_scnt, 2'b11);
`endif

    // reset while busy
    cyc(); ex_is_md = 1;
    #2; chk("rb_start", md_start, 1);
    cyc();
    #2; chk("rb_busy", s_if, 1);
    cyc(); rst = 1;
    #2; chk("rb_rst_all", {md_start, s_if, s_id, s_ex, f_mem}, 0);
    cyc(); rst = 0; ex_is_md = 0; md_done = 1;
    #2; chk("rb_done_ign", {md_start, s_if, s_ex, f_mem}, 0);
    cyc(); md_done = 0; ex_is_load = 1; ex_rd = 3; id_rs1 = 3;
    #2; chk("rb_idle_lu", s_if, 1);

    // randomized phase checked by the compare process
    for (int n = 0; n < 4000; n++) begin
      cyc();
      rst        = ($urandom_range(0, 199) == 0);
      id_rs1     = AW'($urandom_range(0, 3)); id_rs2 = AW'($urandom_range(0, 3));
      ex_rs1     = AW'($urandom_range(0, 3)); ex_rs2 = AW'($urandom_range(0, 3));
      ex_rd      = AW'($urandom_range(0, 3)); mem_rd = AW'($urandom_range(0, 3));
      wb_rd      = AW'($urandom_range(0, 3));
      mem_we     = $urandom_range(0, 1); wb_we = $urandom_range(0, 1);
      ex_is_load = ($urandom_range(0, 2) == 0);
      ex_is_md   = ($urandom_range(0, 9) == 0);
      ex_br      = ($urandom_range(0, 4) == 0);
      md_done    = ($urandom_range(0, 5) == 0);
    end
    cyc(); clr();
    @(posedge clk); #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
